// File: rtl/musa_uart_pkg.sv
// Shared UART definitions: receiver state encodings, byte width and bit-period helper.
// Used by uart_rx_byte and uart_mem_loader.
package musa_uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-FF synchronizer, mid-bit sampling FSM, one-cycle valid/err pulses.
// Optional even parity (9th bit) when UART_PARITY_EN is defined; otherwise 8N1.
module uart_rx_byte
    import musa_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_i,
    output logic [UART_BYTE_W-1:0] byte_o,
    output logic                   valid_o,
    output logic                   err_o
);

    localparam int HALF_BIT = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    logic                   rx_meta_q;
    logic                   rx_sync_q;
    rx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [UART_BYTE_W-1:0] shift_q, shift_d;
`ifdef UART_PARITY_EN
    logic                   par_err_q, par_err_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
`ifdef UART_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
`ifdef UART_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_o = 1'b0;
        err_o   = 1'b0;
`ifdef UART_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_sync_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[UART_BYTE_W-1:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    par_err_d = (rx_sync_q != ^shift_q);
                    state_d   = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
`ifdef UART_PARITY_EN
                    if (rx_sync_q && !par_err_q) begin
`else
                    if (rx_sync_q) begin
`endif
                        valid_o = 1'b1;
                    end else begin
                        err_o = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign byte_o = shift_q;

endmodule

// File: rtl/uart_mem_loader.sv
// UART-to-data-memory loader: packs received bytes little-endian into words and writes them
// at sequential addresses while a session is armed. Optional parity via UART_PARITY_EN.
module uart_mem_loader
    import musa_uart_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    CLK_FREQ   = 50_000_000,
    parameter int                    BAUD       = 115200,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(1),
    parameter int                    MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  start_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_mem_wr_en_out,
    output logic                  busy_out,
    output logic [15:0]           word_count_out,
    output logic                  frame_err_out
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int LANES        = DATA_WIDTH / UART_BYTE_W;
    localparam int IDX_W        = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
    localparam logic [15:0]      MAX_CNT  = 16'(MAX_WORDS);

    logic [UART_BYTE_W-1:0] rx_byte;
    logic                   rx_valid;
    logic                   rx_err;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk    (clk),
        .rst    (rst),
        .rx_i   (rx_in),
        .byte_o (rx_byte),
        .valid_o(rx_valid),
        .err_o  (rx_err)
    );

    logic                  busy_q, busy_d;
    logic [15:0]           count_q, count_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic                  wr_en_q, wr_en_d;
    logic                  err_q, err_d;

    logic                  room;
    logic                  accept;
    logic [DATA_WIDTH-1:0] word_next;

    // No bytes are taken once the session quota has been written.
    assign room   = busy_q && (count_q != MAX_CNT);
    assign accept = room && rx_valid;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign word_next[gi*UART_BYTE_W +: UART_BYTE_W] =
                (accept && (idx_q == IDX_W'(gi))) ? rx_byte
                                                  : word_q[gi*UART_BYTE_W +: UART_BYTE_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= 1'b0;
            count_q     <= '0;
            idx_q       <= '0;
            word_q      <= '0;
            data_q      <= '0;
            addr_q      <= '0;
            next_addr_q <= '0;
            wr_en_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            next_addr_q <= next_addr_d;
            wr_en_q     <= wr_en_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        busy_d      = busy_q;
        count_d     = count_q;
        idx_d       = idx_q;
        word_d      = word_q;
        data_d      = data_q;
        addr_d      = addr_q;
        next_addr_d = next_addr_q;
        wr_en_d     = 1'b0;
        err_d       = err_q;
        if (start_in && !busy_q) begin
            busy_d      = 1'b1;
            count_d     = '0;
            idx_d       = '0;
            err_d       = 1'b0;
            next_addr_d = BASE_ADDR;
        end else if (busy_q) begin
            // Release the port the cycle after the final strobe.
            if (wr_en_q && count_q == MAX_CNT) begin
                busy_d = 1'b0;
            end
            if (room && rx_err) begin
                idx_d = '0;
                err_d = 1'b1;
            end else if (accept) begin
                word_d = word_next;
                if (idx_q == LAST_IDX) begin
                    idx_d       = '0;
                    wr_en_d     = 1'b1;
                    data_d      = word_next;
                    addr_d      = next_addr_q;
                    next_addr_d = next_addr_q + ADDR_STEP;
                    count_d     = count_q + 16'd1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end
    end

    assign addr_out           = addr_q;
    assign data_out           = data_q;
    assign data_mem_wr_en_out = wr_en_q;
    assign busy_out           = busy_q;
    assign word_count_out     = count_q;
    assign frame_err_out      = err_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Self-checking bench for uart_mem_loader: table of two-word sessions plus hand sequences,
// with a write scoreboard checked on every strobe. Parity case under UART_PARITY_EN.
module tb_uart_mem_loader;

    localparam int CPB = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_in = 1'b1;
    logic        start_in = 1'b0;
    logic [31:0] addr_out;
    logic [31:0] data_out;
    logic        wr_en;
    logic        busy_out;
    logic [15:0] word_count_out;
    logic        frame_err_out;

    uart_mem_loader #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .CLK_FREQ  (1_000_000),
        .BAUD      (100_000),
        .BASE_ADDR (32'h40),
        .ADDR_STEP (32'h1),
        .MAX_WORDS (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .rx_in             (rx_in),
        .start_in          (start_in),
        .addr_out          (addr_out),
        .data_out          (data_out),
        .data_mem_wr_en_out(wr_en),
        .busy_out          (busy_out),
        .word_count_out    (word_count_out),
        .frame_err_out     (frame_err_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    typedef struct packed {
        logic [63:0] bytes;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   strobes = 0;
    logic prev_wr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest pending write.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (wr_en) begin
                strobes++;
                check("strobe_one_cycle", {31'd0, prev_wr}, 32'd0);
                check("strobe_expected", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("wr_addr", addr_out, e.addr);
                    check("wr_data", data_out, e.data);
                    $display("write addr=0x%0h data=0x%0h count=%0d", addr_out, data_out, word_count_out);
                end
            end
            prev_wr = wr_en;
        end
    end

    task automatic rx_bit(input logic v);
        @(negedge clk);
        rx_in = v;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(b[i]);
`ifdef UART_PARITY_EN
        rx_bit(^b);
`endif
        rx_bit(1'b1);
    endtask

    task automatic send_bad_stop(input logic [7:0] b);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(b[i]);
`ifdef UART_PARITY_EN
        rx_bit(^b);
`endif
        rx_bit(1'b0);
        rx_bit(1'b1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        check("drain_pending", sb.size(), 32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    vec_t vecs[3];
    int   s0;

    initial begin
        vecs[0] = '{bytes: 64'h11223344_55667788, w0: 32'h55667788, w1: 32'h11223344};
        vecs[1] = '{bytes: 64'hDEADBEEF_00FF8001, w0: 32'h00FF8001, w1: 32'hDEADBEEF};
        vecs[2] = '{bytes: 64'h0F1E2D3C_4B5A6978, w0: 32'h4B5A6978, w1: 32'h0F1E2D3C};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_addr", addr_out, 32'd0);
        check("rst_data", data_out, 32'd0);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_busy", {31'd0, busy_out}, 32'd0);
        check("rst_count", {16'd0, word_count_out}, 32'd0);
        check("rst_ferr", {31'd0, frame_err_out}, 32'd0);

        // Single word; a start while busy is ignored.
        pulse_start();
        check("t1_busy", {31'd0, busy_out}, 32'd1);
        expect_wr(32'h40, 32'h12345678);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        wait_drain();
        check("t1_count", {16'd0, word_count_out}, 32'd1);
        check("t1_hold_addr", addr_out, 32'h40);
        check("t1_hold_data", data_out, 32'h12345678);
        pulse_start();
        check("t1_restart_ignored", {16'd0, word_count_out}, 32'd1);
        expect_wr(32'h41, 32'hCAFE0102);
        send_word(32'hCAFE0102);
        wait_drain();
        check("t1_end_busy", {31'd0, busy_out}, 32'd0);
        check("t1_end_count", {16'd0, word_count_out}, 32'd2);

        // Table: back-to-back 8-byte sessions.
        for (int v = 0; v < 3; v++) begin
            pulse_start();
            check("tv_busy", {31'd0, busy_out}, 32'd1);
            check("tv_count0", {16'd0, word_count_out}, 32'd0);
            s0 = strobes;
            expect_wr(32'h40, vecs[v].w0);
            expect_wr(32'h41, vecs[v].w1);
            for (int k = 0; k < 8; k++) send_byte(vecs[v].bytes[8*k +: 8]);
            wait_drain();
            check("tv_strobes", strobes - s0, 32'd2);
            check("tv_count", {16'd0, word_count_out}, 32'd2);
            check("tv_busy_end", {31'd0, busy_out}, 32'd0);
            check("tv_ferr", {31'd0, frame_err_out}, 32'd0);
        end

        // Framing error drops the partial word; error stays sticky.
        pulse_start();
        send_byte(8'h01); send_byte(8'h02);
        send_bad_stop(8'h03);
        check("t3_ferr", {31'd0, frame_err_out}, 32'd1);
        expect_wr(32'h40, 32'h07060504);
        send_byte(8'h04); send_byte(8'h05); send_byte(8'h06); send_byte(8'h07);
        wait_drain();
        check("t3_count", {16'd0, word_count_out}, 32'd1);
        expect_wr(32'h41, 32'hA5A55A5A);
        send_word(32'hA5A55A5A);
        wait_drain();
        check("t3_busy_end", {31'd0, busy_out}, 32'd0);
        check("t3_ferr_sticky", {31'd0, frame_err_out}, 32'd1);

        // One-clock glitch is rejected; then reset mid-word.
        pulse_start();
        check("t4_ferr_cleared", {31'd0, frame_err_out}, 32'd0);
        s0 = strobes;
        @(negedge clk); rx_in = 1'b0;
        @(negedge clk); rx_in = 1'b1;
        repeat (60) @(negedge clk);
        check("t4_strobes", strobes - s0, 32'd0);
        check("t4_count", {16'd0, word_count_out}, 32'd0);
        check("t4_ferr", {31'd0, frame_err_out}, 32'd0);
        send_byte(8'h99); send_byte(8'h88);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("t6_busy", {31'd0, busy_out}, 32'd0);
        check("t6_count", {16'd0, word_count_out}, 32'd0);
        check("t6_addr", addr_out, 32'd0);
        check("t6_data", data_out, 32'd0);
        check("t6_strobes", strobes - s0, 32'd0);
        pulse_start();
        expect_wr(32'h40, 32'h44332211);
        send_word(32'h44332211);
        wait_drain();
        check("t6_count_after", {16'd0, word_count_out}, 32'd1);

        // Session quota: bytes while idle ignored, only MAX_WORDS writes.
        expect_wr(32'h41, 32'h55555555);
        send_word(32'h55555555);
        wait_drain();
        s0 = strobes;
        send_word(32'h66666666);
        repeat (20) @(negedge clk);
        check("t5_idle_strobes", strobes - s0, 32'd0);
        check("t5_idle_busy", {31'd0, busy_out}, 32'd0);
        pulse_start();
        expect_wr(32'h40, 32'h0D0C0B0A);
        expect_wr(32'h41, 32'h1D1C1B1A);
        send_word(32'h0D0C0B0A);
        send_word(32'h1D1C1B1A);
        check("t5_busy_low", {31'd0, busy_out}, 32'd0);
        send_word(32'h2D2C2B2A);
        wait_drain();
        repeat (20) @(negedge clk);
        check("t5_strobes", strobes - s0, 32'd2);
        check("t5_count", {16'd0, word_count_out}, 32'd2);

`ifdef UART_PARITY_EN
        pulse_start();
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(1'b1);
        rx_bit(1'b1);
        rx_bit(1'b1);
        check("par_ferr", {31'd0, frame_err_out}, 32'd1);
        expect_wr(32'h40, 32'h87654321);
        send_word(32'h87654321);
        wait_drain();
        check("par_count", {16'd0, word_count_out}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
